// File: rtl/chiplet_types_pkg.sv
// chiplet_types_pkg
// Shared types and helpers for the chiplet switch pipeline.
//   outport_t : index of a switch output port (default four-port switch)
//   PORT_IDLE / PORT_LOCKED : per-outport wormhole state encodings
//   rr_next   : wrapped increment used for round-robin pointers
package chiplet_types_pkg;

   localparam int DEF_NUM_OUTPORTS = 4;
   localparam int DEF_OSEL_W       = $clog2(DEF_NUM_OUTPORTS);

   typedef logic [DEF_OSEL_W-1:0] outport_t;

   localparam logic [0:0] PORT_IDLE   = 1'b0;
   localparam logic [0:0] PORT_LOCKED = 1'b1;

   // Returns ptr+1, wrapping to 0 once it would reach n.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      if (ptr + 1 >= n) return 0;
      return ptr + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter: picks the first asserted request
// scanning upward from the priority pointer, wrapping modulo NUM_BUFFERS.
//   req       in  [NUM_BUFFERS]  request vector
//   ptr       in  [SEL_W]        highest-priority requester index
//   gnt       out [NUM_BUFFERS]  one-hot grant (all zero when no request)
//   idx       out [SEL_W]        encoded index of the granted requester
//   any_grant out 1              some request was granted
module rr_arbiter #(
   parameter int NUM_BUFFERS = 4,
   localparam int SEL_W = $clog2(NUM_BUFFERS)
) (
   input  logic [NUM_BUFFERS-1:0] req,
   input  logic [SEL_W-1:0]       ptr,
   output logic [NUM_BUFFERS-1:0] gnt,
   output logic [SEL_W-1:0]       idx,
   output logic                   any_grant
);

   always_comb begin
      logic [SEL_W-1:0] cand;
      gnt       = '0;
      idx       = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
         cand = SEL_W'((int'(ptr) + i) % NUM_BUFFERS);
         if (!any_grant && req[cand]) begin
            any_grant = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator
// Arbitrates each switch output port among the input buffers that route to
// it. Round-robin among single flits and packet heads; once a head wins, the
// port stays bound to that buffer (wormhole lock) until its tail transfers.
//   clk, rst     clock and synchronous active-high reset
//   req_valid    [NUM_BUFFERS]          buffer head holds a routed flit
//   req_outport  [NUM_BUFFERS][OSEL_W]  target port of each head flit
//   req_tail     [NUM_BUFFERS]          head flit is the packet tail
//   out_ready    [NUM_OUTPORTS]         downstream port has a credit
//   grant        [NUM_BUFFERS]          pop this buffer's head flit
//   out_valid    [NUM_OUTPORTS]         port carries a flit this cycle
//   out_sel      [NUM_OUTPORTS][SEL_W]  crossbar select (driving buffer)
//   port_locked  [NUM_OUTPORTS]         port is mid-packet
module switch_allocator
   import chiplet_types_pkg::*;
#(
   parameter int NUM_BUFFERS  = 4,
   parameter int NUM_OUTPORTS = 4,
   localparam int SEL_W  = $clog2(NUM_BUFFERS),
   localparam int OSEL_W = $clog2(NUM_OUTPORTS)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_BUFFERS-1:0]               req_valid,
   input  logic [NUM_BUFFERS-1:0][OSEL_W-1:0]   req_outport,
   input  logic [NUM_BUFFERS-1:0]               req_tail,
   input  logic [NUM_OUTPORTS-1:0]              out_ready,
   output logic [NUM_BUFFERS-1:0]               grant,
   output logic [NUM_OUTPORTS-1:0]              out_valid,
   output logic [NUM_OUTPORTS-1:0][SEL_W-1:0]   out_sel,
   output logic [NUM_OUTPORTS-1:0]              port_locked
);

   logic [NUM_OUTPORTS-1:0] lock_valid;
   logic [SEL_W-1:0]        lock_owner [NUM_OUTPORTS];
   logic [SEL_W-1:0]        rr_ptr     [NUM_OUTPORTS];

   logic [NUM_BUFFERS-1:0]  arb_req    [NUM_OUTPORTS];
   logic [NUM_BUFFERS-1:0]  arb_gnt    [NUM_OUTPORTS];
   logic [SEL_W-1:0]        arb_idx    [NUM_OUTPORTS];
   logic [NUM_OUTPORTS-1:0] arb_any;

   // Candidate vector per port: buffers whose head flit targets that port.
   always_comb begin
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
         for (int b = 0; b < NUM_BUFFERS; b++) begin
            arb_req[p][b] = req_valid[b] && (req_outport[b] == OSEL_W'(p));
         end
      end
   end

   for (genvar gp = 0; gp < NUM_OUTPORTS; gp++) begin : g_arb
      rr_arbiter #(.NUM_BUFFERS(NUM_BUFFERS)) u_arb (
         .req       (arb_req[gp]),
         .ptr       (rr_ptr[gp]),
         .gnt       (arb_gnt[gp]),
         .idx       (arb_idx[gp]),
         .any_grant (arb_any[gp])
      );
   end

   // A locked port only serves its owner, and only while the owner still
   // targets it; the arbiter result is used only when the port is idle.
   // out_sel defaults to lock_owner so it never floats when idle.
   always_comb begin
      grant     = '0;
      out_valid = '0;
      for (int p = 0; p < NUM_OUTPORTS; p++) begin
         out_sel[p] = lock_owner[p];
         if (!rst && out_ready[p]) begin
            if (lock_valid[p] == PORT_LOCKED) begin
               if (req_valid[lock_owner[p]] &&
                   (req_outport[lock_owner[p]] == OSEL_W'(p))) begin
                  grant[lock_owner[p]] = 1'b1;
                  out_valid[p]         = 1'b1;
               end
            end else if (arb_any[p]) begin
               grant        = grant | arb_gnt[p];
               out_valid[p] = 1'b1;
               out_sel[p]   = arb_idx[p];
            end
         end
      end
   end

   // State only moves on a transfer: an idle winner advances the pointer and
   // locks on a head, a locked owner's tail releases the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_valid <= '0;
         for (int p = 0; p < NUM_OUTPORTS; p++) begin
            lock_owner[p] <= '0;
            rr_ptr[p]     <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_OUTPORTS; p++) begin
            if (out_valid[p]) begin
               if (lock_valid[p] == PORT_LOCKED) begin
                  if (req_tail[lock_owner[p]]) lock_valid[p] <= PORT_IDLE;
               end else begin
                  rr_ptr[p] <= SEL_W'(rr_next(32'(arb_idx[p]), NUM_BUFFERS));
                  if (!req_tail[arb_idx[p]]) begin
                     lock_valid[p] <= PORT_LOCKED;
                     lock_owner[p] <= arb_idx[p];
                  end
               end
            end
         end
      end
   end

   assign port_locked = lock_valid;

endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator
// Directed bench for switch_allocator (4 buffers, 4 ports). Each step drives
// inputs just after a rising edge, queues the outputs it expects, and checks
// them at the following falling edge.
module tb_switch_allocator;

   logic                 clk;
   logic                 rst;
   logic [3:0]           req_valid;
   logic [3:0][1:0]      req_outport;
   logic [3:0]           req_tail;
   logic [3:0]           out_ready;
   logic [3:0]           grant;
   logic [3:0]           out_valid;
   logic [3:0][1:0]      out_sel;
   logic [3:0]           port_locked;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [3:0] grant;
      logic [3:0] valid;
      logic [3:0] sel_mask;
      logic [7:0] sel;
      logic [3:0] locked;
   } exp_t;

   exp_t exp_q[$];

   switch_allocator #(.NUM_BUFFERS(4), .NUM_OUTPORTS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_outport (req_outport),
      .req_tail    (req_tail),
      .out_ready   (out_ready),
      .grant       (grant),
      .out_valid   (out_valid),
      .out_sel     (out_sel),
      .port_locked (port_locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_reqs();
      req_valid   = '0;
      req_outport = '0;
      req_tail    = '0;
   endtask

   task automatic set_req(input int b, input int port, input bit tail);
      req_valid[b]   = 1'b1;
      req_outport[b] = 2'(port);
      req_tail[b]    = tail;
   endtask

   // Queue what the outputs must be for the inputs just driven.
   task automatic apply_stimulus(input string tag, input logic [3:0] g,
                                 input logic [3:0] v, input logic [3:0] m,
                                 input logic [7:0] s, input logic [3:0] l);
      exp_t e;
      e.tag = tag; e.grant = g; e.valid = v; e.sel_mask = m; e.sel = s; e.locked = l;
      exp_q.push_back(e);
   endtask

   // Compare at the falling edge, then step to just after the next rising edge.
   task automatic check_output();
      exp_t       e;
      logic [7:0] m;
      @(negedge clk);
      checks++;
      assert (exp_q.size() != 0) else begin
         failures++;
         $error("[TB] FAIL scoreboard observed=empty expected=entry");
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         for (int p = 0; p < 4; p++) m[2*p +: 2] = {2{e.sel_mask[p]}};
         checks++;
         assert (grant === e.grant) else begin
            failures++;
            $error("[TB] FAIL %s grant observed=%b expected=%b", e.tag, grant, e.grant);
         end
         checks++;
         assert (out_valid === e.valid) else begin
            failures++;
            $error("[TB] FAIL %s out_valid observed=%b expected=%b", e.tag, out_valid, e.valid);
         end
         checks++;
         assert ((8'(out_sel) & m) === (e.sel & m)) else begin
            failures++;
            $error("[TB] FAIL %s out_sel observed=%h expected=%h mask=%h",
                   e.tag, 8'(out_sel) & m, e.sel & m, m);
         end
         checks++;
         assert (port_locked === e.locked) else begin
            failures++;
            $error("[TB] FAIL %s port_locked observed=%b expected=%b", e.tag, port_locked, e.locked);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 4'b1111;
      clear_reqs();
      for (int b = 0; b < 4; b++) set_req(b, 0, 1'b1);
      @(posedge clk);
      #1;

      // Reset: everyone requesting, nothing granted, all state cleared.
      apply_stimulus("reset", 4'b0000, 4'b0000, 4'b1111, 8'h00, 4'b0000);
      check_output();
      rst = 1'b0;
      apply_stimulus("post_reset_b0", 4'b0001, 4'b0001, 4'b0001, 8'h00, 4'b0000);
      check_output();

      // Single-flit round robin on port 1.
      clear_reqs();
      for (int b = 0; b < 3; b++) set_req(b, 1, 1'b1);
      apply_stimulus("rr_b0", 4'b0001, 4'b0010, 4'b0010, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000);
      check_output();
      apply_stimulus("rr_b1", 4'b0010, 4'b0010, 4'b0010, {2'd0, 2'd0, 2'd1, 2'd0}, 4'b0000);
      check_output();
      apply_stimulus("rr_b2", 4'b0100, 4'b0010, 4'b0010, {2'd0, 2'd0, 2'd2, 2'd0}, 4'b0000);
      check_output();
      apply_stimulus("rr_wrap_b0", 4'b0001, 4'b0010, 4'b0010, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000);
      check_output();

      // Move port 0's pointer to buffer 2, then a 3-flit packet from buffer 2.
      clear_reqs();
      set_req(1, 0, 1'b1);
      apply_stimulus("prep_b1", 4'b0010, 4'b0001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, 4'b0000);
      check_output();
      set_req(2, 0, 1'b0);
      apply_stimulus("worm_head", 4'b0100, 4'b0001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0000);
      check_output();
      apply_stimulus("worm_body", 4'b0100, 4'b0001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0001);
      check_output();
      set_req(2, 0, 1'b1);
      apply_stimulus("worm_tail", 4'b0100, 4'b0001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0001);
      check_output();
      req_valid[2] = 1'b0;
      apply_stimulus("worm_after_b1", 4'b0010, 4'b0001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, 4'b0000);
      check_output();

      // Bubble and backpressure on port 2 locked to buffer 3; buffer 0 competes.
      clear_reqs();
      set_req(3, 2, 1'b0);
      apply_stimulus("bp_head", 4'b1000, 4'b0100, 4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0000);
      check_output();
      req_valid[3] = 1'b0;
      set_req(0, 2, 1'b1);
      apply_stimulus("bp_bubble", 4'b0000, 4'b0000, 4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0100);
      check_output();
      set_req(3, 2, 1'b1);
      out_ready[2] = 1'b0;
      apply_stimulus("bp_stall1", 4'b0000, 4'b0000, 4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0100);
      check_output();
      apply_stimulus("bp_stall2", 4'b0000, 4'b0000, 4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0100);
      check_output();
      out_ready[2] = 1'b1;
      apply_stimulus("bp_tail", 4'b1000, 4'b0100, 4'b0100, {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0100);
      check_output();
      req_valid[3] = 1'b0;
      apply_stimulus("bp_release_b0", 4'b0001, 4'b0100, 4'b0100, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000);
      check_output();

      // Two ports granted in the same cycle.
      clear_reqs();
      set_req(0, 3, 1'b1);
      set_req(1, 2, 1'b1);
      apply_stimulus("parallel", 4'b0011, 4'b1100, 4'b1100, {2'd0, 2'd1, 2'd0, 2'd0}, 4'b0000);
      check_output();

      // Reset while buffer 1 holds port 0 mid-packet.
      clear_reqs();
      set_req(1, 0, 1'b0);
      apply_stimulus("mid_head_b1", 4'b0010, 4'b0001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, 4'b0000);
      check_output();
      rst = 1'b1;
      apply_stimulus("mid_rst", 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0001);
      check_output();
      rst = 1'b0;
      clear_reqs();
      set_req(3, 0, 1'b0);
      apply_stimulus("mid_new_b3", 4'b1000, 4'b0001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd3}, 4'b0000);
      check_output();
      set_req(3, 0, 1'b1);
      apply_stimulus("mid_tail_b3", 4'b1000, 4'b0001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd3}, 4'b0001);
      check_output();

      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
